reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one bank of 16-bit Register instances among NUM_REQ requesters (e.g. control unit, address-generation logic, debug port).
- Drives each register's E, FunSel and I. Turns a requester command into a register operation of 1 or 2 cycles; the 2-cycle operation is a bytewise 16-bit load over the 8-bit I[7:0] write path.
- One operation in flight at a time. Sits between the control logic and the register bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REG, 4, number of registers in the bank (2..8).
- RSEL_W, $clog2(NUM_REG), width of the register-select field.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  NUM_REQ  per-requester request level.
- Op  in  3*NUM_REQ  per-requester command; slice k belongs to requester k.
- RegSel  in  RSEL_W*NUM_REQ  per-requester target register index.
- Data  in  16*NUM_REQ  per-requester write data.
- Gnt  out  NUM_REQ  one-hot grant pulse, 1 cycle.
- Done  out  NUM_REQ  one-hot completion pulse, 1 cycle.
- Err  out  1  illegal-command flag; pulses with Done.
- Busy  out  1  high whenever state is not IDLE.
- RegE  out  NUM_REG  one-hot enable to the register bank.
- RegFunSel  out  3  FunSel shared by all registers.
- RegI  out  16  I bus shared by all registers.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE; Ptr=0; holding registers cleared.
  - Gnt=0, Done=0, Err=0, Busy=0, RegE=0, RegFunSel=3'b000, RegI=16'h0000.
- All outputs decode from registered state and holding registers. There is no combinational path from Req/Op/Data to any output.
- Commands (Op) map to register FunSel as follows:
  - 000 DEC → 000
  - 001 INC → 001
  - 010 LOAD → 010, I=Data
  - 011 CLR → 011
  - 100 LOAD_BYTES → two cycles: 101 with I={8'h00,Data[7:0]}, then 110 with I={8'h00,Data[15:8]}
  - 101 WRLOW → 101, I=Data
  - 110 WRHIGH → 110, I=Data
  - 111 illegal: no register write; Err pulses with Done.
- State machine:
  - IDLE:
    - If any Req bit is set, pick the winner W as the first set Req at or after Ptr, scanning upward modulo NUM_REQ.
    - Latch Op[W], RegSel[W], Data[W] and W.
    - Go to EXEC.
  - EXEC:
    - Gnt[W]=1 for this cycle only.
    - RegE[sel]=1, with RegFunSel/RegI per the command map; for LOAD_BYTES this cycle is the low-byte write.
    - For illegal commands, RegE=0.
    - Next state: EXEC_HI for LOAD_BYTES, otherwise RESP.
  - EXEC_HI: RegE[sel]=1, RegFunSel=110, RegI={8'h00,Data[15:8]}; next state RESP.
  - RESP:
    - RegE=0; Done[W]=1; Err=1 if the command was illegal.
    - Ptr<=(W+1) mod NUM_REQ.
    - Next state IDLE.
- Latency:
  - The register is updated on the rising edge ending EXEC (EXEC_HI for LOAD_BYTES).
  - Request-to-Done: 3 cycles for single-cycle commands, 4 for LOAD_BYTES.
  - Back-to-back throughput: one command per 3 (or 4) cycles.
- Handshake:
  - A requester holds Req, Op, RegSel and Data stable until it sees Gnt.
  - Data is captured in IDLE, so changes after Gnt have no effect.
  - The requester deasserts Req no later than the RESP cycle. A Req still high in the following IDLE is a new request.
- Outside EXEC/EXEC_HI: RegE=0, RegFunSel=000, RegI=0.
- RegSel >= NUM_REG is treated as illegal, identical to Op=111.
- Simultaneous requests are served strictly round-robin, with no starvation. A requester waits at most NUM_REQ-1 services.
- Reset during EXEC_HI leaves the target register with the new low byte and the old high byte. This is accepted; requesters re-issue the command after reset.

Decomposition:
- Shared package reg_ctrl_pkg holds:
  - Op encodings (OP_DEC … OP_ILLEGAL).
  - FunSel constants (FS_DEC=000 … FS_SIGN=111).
  - State enum (IDLE, EXEC, EXEC_HI, RESP).
- One natural sub-module: rr_pick. It is combinational, takes Req and Ptr, and returns the one-hot winner plus its index, so the arbitration can be reused and tested on its own.
- FSM, holding registers and output decode stay in the top module.

Test Plan:
- Reset: hold Reset=0 with Req=4'b1111 → all outputs 0, Busy=0; release → first grant goes to requester 0.
- Single INC: Req[2]=1, Op=001, RegSel=1 from IDLE → Gnt[2] next cycle together with RegE=4'b0010 and RegFunSel=001; Done[2] one cycle later; register model R1 increments by 1.
- LOAD_BYTES: Req[1], Op=100, RegSel=3, Data=16'hA55A → EXEC drives FunSel 101 with RegI=16'h005A, then EXEC_HI drives 110 with RegI=16'h00A5; Done[1] at cycle 4; R3=16'hA55A.
- Round-robin: Req=4'b1111 held continuously → grant order 0,1,2,3,0 with Gnt spaced 3 cycles apart; with Req=4'b1001 after serving 0 → requester 3 next, then 0.
- Illegal: Op=111 (and separately RegSel=5 with NUM_REG=4) → Gnt, RegE stays 0 throughout, Done and Err pulse together, bank unchanged.
- Reset mid-op: assert Reset during EXEC_HI of a LOAD_BYTES of 16'h1234 to a register holding 16'hFFFF → outputs clear immediately, no Done, register holds 16'hFF34.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
// Shared encodings for the register-bank access path: requester opcodes,
// register FunSel codes, arbiter/sequencer states and the latched command.
package reg_ctrl_pkg;

    localparam logic [2:0] OP_DEC        = 3'b000;
    localparam logic [2:0] OP_INC        = 3'b001;
    localparam logic [2:0] OP_LOAD       = 3'b010;
    localparam logic [2:0] OP_CLR        = 3'b011;
    localparam logic [2:0] OP_LOAD_BYTES = 3'b100;
    localparam logic [2:0] OP_WRLOW      = 3'b101;
    localparam logic [2:0] OP_WRHIGH     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL    = 3'b111;

    localparam logic [2:0] FS_DEC    = 3'b000;
    localparam logic [2:0] FS_INC    = 3'b001;
    localparam logic [2:0] FS_LOAD   = 3'b010;
    localparam logic [2:0] FS_CLR    = 3'b011;
    localparam logic [2:0] FS_RSVD   = 3'b100;
    localparam logic [2:0] FS_WRLOW  = 3'b101;
    localparam logic [2:0] FS_WRHIGH = 3'b110;
    localparam logic [2:0] FS_SIGN   = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        EXEC_HI = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Command captured from the winning requester.
    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] data;
    } cmd_t;

    // FunSel for the first (or only) execute cycle of a legal command.
    function automatic logic [2:0] op2fs(input logic [2:0] op);
        case (op)
            OP_DEC:        op2fs = FS_DEC;
            OP_INC:        op2fs = FS_INC;
            OP_LOAD:       op2fs = FS_LOAD;
            OP_CLR:        op2fs = FS_CLR;
            OP_LOAD_BYTES: op2fs = FS_WRLOW;
            OP_WRLOW:      op2fs = FS_WRLOW;
            OP_WRHIGH:     op2fs = FS_WRHIGH;
            default:       op2fs = FS_DEC;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr,
// scanning upward modulo N. Returns one-hot winner, its index and a valid flag.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Priority scan starting at ptr; the first hit locks out the rest.
    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter and sequencer in front of a bank of 16-bit registers.
// One command in flight; each becomes a 1- or 2-cycle register operation
// followed by a one-cycle Done/Err response.
module reg_access_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_REG = 4,
    parameter int RSEL_W  = $clog2(NUM_REG)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [3*NUM_REQ-1:0]      Op,
    input  logic [RSEL_W*NUM_REQ-1:0] RegSel,
    input  logic [16*NUM_REQ-1:0]     Data,
    output logic [NUM_REQ-1:0]        Gnt,
    output logic [NUM_REQ-1:0]        Done,
    output logic                      Err,
    output logic                      Busy,
    output logic [NUM_REG-1:0]        RegE,
    output logic [2:0]                RegFunSel,
    output logic [15:0]               RegI
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state, state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win;
    logic [NUM_REQ-1:0]   win_oh;
    cmd_t                 cmd;
    logic [RSEL_W-1:0]    sel;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    cmd_t                 pick_cmd;
    logic [RSEL_W-1:0]    pick_sel;

    logic [NUM_REG-1:0]   sel_oh;
    logic                 illegal;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req (Req),
        .ptr (ptr),
        .gnt (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Mux the winner's command fields out of the flattened request buses.
    always_comb begin
        pick_cmd = '0;
        pick_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_cmd.op   = Op[3*k +: 3];
                pick_cmd.data = Data[16*k +: 16];
                pick_sel      = RegSel[RSEL_W*k +: RSEL_W];
            end
        end
    end

    // A select past the bank shifts the bit out, leaving sel_oh empty; that
    // doubles as the out-of-range check without a width-dependent compare.
    always_comb begin
        sel_oh  = NUM_REG'(1) << sel;
        illegal = (cmd.op == OP_ILLEGAL) || (sel_oh == '0);
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the winner in IDLE; advance the round-robin pointer in RESP.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ptr    <= '0;
            win    <= '0;
            win_oh <= '0;
            cmd    <= '0;
            sel    <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                win    <= pick_idx;
                win_oh <= pick_oh;
                cmd    <= pick_cmd;
                sel    <= pick_sel;
            end
            if (state == RESP)
                ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // Next state and output decode, purely from registered state.
    always_comb begin
        state_nxt = state;
        Gnt       = '0;
        Done      = '0;
        Err       = 1'b0;
        RegE      = '0;
        RegFunSel = FS_DEC;
        RegI      = 16'h0000;
        Busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_any) state_nxt = EXEC;
            end
            EXEC: begin
                Gnt = win_oh;
                if (!illegal) begin
                    RegE      = sel_oh;
                    RegFunSel = op2fs(cmd.op);
                    case (cmd.op)
                        OP_LOAD, OP_WRLOW, OP_WRHIGH: RegI = cmd.data;
                        OP_LOAD_BYTES:                RegI = {8'h00, cmd.data[7:0]};
                        default:                      RegI = 16'h0000;
                    endcase
                end
                state_nxt = (!illegal && cmd.op == OP_LOAD_BYTES) ? EXEC_HI : RESP;
            end
            EXEC_HI: begin
                RegE      = sel_oh;
                RegFunSel = FS_WRHIGH;
                RegI      = {8'h00, cmd.data[15:8]};
                state_nxt = RESP;
            end
            RESP: begin
                Done      = win_oh;
                Err       = illegal;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural register bank
// hanging off RegE/RegFunSel/RegI.
module tb_reg_access_arbiter;
    import reg_ctrl_pkg::*;

    localparam int NQ = 4;
    localparam int NR = 4;
    localparam int SW = 3;   // wide enough to express out-of-range selects

    logic              Clock = 1'b0;
    logic              Reset;
    logic [NQ-1:0]     Req;
    logic [3*NQ-1:0]   Op;
    logic [SW*NQ-1:0]  RegSel;
    logic [16*NQ-1:0]  Data;
    logic [NQ-1:0]     Gnt;
    logic [NQ-1:0]     Done;
    logic              Err;
    logic              Busy;
    logic [NR-1:0]     RegE;
    logic [2:0]        RegFunSel;
    logic [15:0]       RegI;

    int nerr = 0;
    int nchk = 0;

    logic [15:0] bank [NR] = '{default: 16'h0000};

    reg_access_arbiter #(.NUM_REQ(NQ), .NUM_REG(NR), .RSEL_W(SW)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Req       (Req),
        .Op        (Op),
        .RegSel    (RegSel),
        .Data      (Data),
        .Gnt       (Gnt),
        .Done      (Done),
        .Err       (Err),
        .Busy      (Busy),
        .RegE      (RegE),
        .RegFunSel (RegFunSel),
        .RegI      (RegI)
    );

    always #5 Clock = ~Clock;

    // Register bank model (not reset by the arbiter's Reset).
    always @(posedge Clock) begin
        for (int r = 0; r < NR; r++) begin
            if (RegE[r]) begin
                case (RegFunSel)
                    3'b000: bank[r] <= bank[r] - 16'd1;
                    3'b001: bank[r] <= bank[r] + 16'd1;
                    3'b010: bank[r] <= RegI;
                    3'b011: bank[r] <= 16'h0000;
                    3'b101: bank[r] <= {bank[r][15:8], RegI[7:0]};
                    3'b110: bank[r] <= {RegI[7:0], bank[r][7:0]};
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic put(input int k, input logic [2:0] op, input logic [SW-1:0] s, input logic [15:0] d);
        Op[3*k +: 3]      = op;
        RegSel[SW*k +: SW] = s;
        Data[16*k +: 16]  = d;
        Req[k]            = 1'b1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},  32'(Gnt),       32'h0);
        chk({tag, "_done"}, 32'(Done),      32'h0);
        chk({tag, "_err"},  32'(Err),       32'h0);
        chk({tag, "_busy"}, 32'(Busy),      32'h0);
        chk({tag, "_rege"}, 32'(RegE),      32'h0);
        chk({tag, "_fs"},   32'(RegFunSel), 32'h0);
        chk({tag, "_regi"}, 32'(RegI),      32'h0);
    endtask

    initial begin
        logic [31:0] e;
        Reset = 1'b0; Req = '0; Op = '0; RegSel = '0; Data = '0;
        for (int k = 0; k < NQ; k++) put(k, OP_INC, 3'd0, 16'h0);

        // Reset held with all requests pending
        step(); step(); step();
        chk_quiet("rst");
        Reset = 1'b1;
        step();
        chk("rst_first_gnt", 32'(Gnt), 32'h1);
        Req = '0;
        step();
        chk("rst_first_done", 32'(Done), 32'h1);
        step();
        chk("rst_r0", 32'(bank[0]), 32'h1);

        // Single INC from requester 2 to R1
        put(2, OP_INC, 3'd1, 16'h0);
        step();
        chk("inc_gnt",  32'(Gnt),       32'h4);
        chk("inc_rege", 32'(RegE),      32'h2);
        chk("inc_fs",   32'(RegFunSel), 32'h1);
        chk("inc_busy", 32'(Busy),      32'h1);
        Req = '0;
        step();
        chk("inc_done", 32'(Done), 32'h4);
        chk("inc_rege_resp", 32'(RegE), 32'h0);
        step();
        chk("inc_idle_busy", 32'(Busy), 32'h0);
        chk("inc_r1", 32'(bank[1]), 32'h1);

        // LOAD_BYTES from requester 1 to R3
        put(1, OP_LOAD_BYTES, 3'd3, 16'hA55A);
        step();
        chk("lb_gnt",  32'(Gnt),       32'h2);
        chk("lb_rege", 32'(RegE),      32'h8);
        chk("lb_fs_lo", 32'(RegFunSel), 32'h5);
        chk("lb_i_lo",  32'(RegI),      32'h005A);
        Req = '0;
        step();
        chk("lb_gnt_hi", 32'(Gnt),       32'h0);
        chk("lb_fs_hi",  32'(RegFunSel), 32'h6);
        chk("lb_i_hi",   32'(RegI),      32'h00A5);
        chk("lb_rege_hi", 32'(RegE),     32'h8);
        step();
        chk("lb_done", 32'(Done), 32'h2);
        step();
        chk("lb_r3", 32'(bank[3]), 32'hA55A);

        // WRLOW from requester 3 to R0; brings the pointer back to 0
        put(3, OP_WRLOW, 3'd0, 16'h12C4);
        step();
        chk("wl_gnt", 32'(Gnt),       32'h8);
        chk("wl_fs",  32'(RegFunSel), 32'h5);
        chk("wl_i",   32'(RegI),      32'h12C4);
        Req = '0;
        step(); step();
        chk("wl_r0", 32'(bank[0]), 32'h00C4);

        // Round robin with everyone requesting INC on R2
        for (int k = 0; k < NQ; k++) put(k, OP_INC, 3'd2, 16'h0);
        for (int g = 0; g < 5; g++) begin
            e = 32'(1) << (g % 4);
            step();
            chk("rr_gnt", 32'(Gnt), e);
            step();
            chk("rr_done", 32'(Done), e);
            step();
            chk("rr_gap", 32'(Gnt), 32'h0);
        end
        Req = 4'b1001;
        step();
        chk("rr_1001_a", 32'(Gnt), 32'h8);
        step(); step(); step();
        chk("rr_1001_b", 32'(Gnt), 32'h1);
        Req = '0;
        step(); step();
        chk("rr_r2", 32'(bank[2]), 32'h7);

        // Illegal opcode from requester 1
        put(1, OP_ILLEGAL, 3'd0, 16'hDEAD);
        step();
        chk("ill_gnt",  32'(Gnt),  32'h2);
        chk("ill_rege", 32'(RegE), 32'h0);
        Req = '0;
        step();
        chk("ill_done", 32'(Done), 32'h2);
        chk("ill_err",  32'(Err),  32'h1);
        chk("ill_rege_resp", 32'(RegE), 32'h0);
        step();
        chk("ill_err_clr", 32'(Err), 32'h0);
        chk("ill_r0", 32'(bank[0]), 32'h00C4);

        // Out-of-range select: LOAD to register 5
        put(2, OP_LOAD, 3'd5, 16'hFFFF);
        step();
        chk("oor_gnt",  32'(Gnt),  32'h4);
        chk("oor_rege", 32'(RegE), 32'h0);
        Req = '0;
        step();
        chk("oor_done", 32'(Done), 32'h4);
        chk("oor_err",  32'(Err),  32'h1);
        step();
        chk("oor_r1", 32'(bank[1]), 32'h1);
        chk("oor_r3", 32'(bank[3]), 32'hA55A);

        // LOAD 16'hFFFF into R1 from requester 3
        put(3, OP_LOAD, 3'd1, 16'hFFFF);
        step();
        chk("ld_gnt", 32'(Gnt),       32'h8);
        chk("ld_fs",  32'(RegFunSel), 32'h2);
        Req = '0;
        step(); step();
        chk("ld_r1", 32'(bank[1]), 32'hFFFF);

        // Reset during EXEC_HI of LOAD_BYTES 16'h1234 into R1
        put(0, OP_LOAD_BYTES, 3'd1, 16'h1234);
        step();
        chk("rmid_gnt",  32'(Gnt),  32'h1);
        chk("rmid_i_lo", 32'(RegI), 32'h0034);
        Req = '0;
        step();
        chk("rmid_fs_hi", 32'(RegFunSel), 32'h6);
        chk("rmid_lowbyte", 32'(bank[1]), 32'hFF34);
        Reset = 1'b0;
        #1;
        chk_quiet("rmid");
        step();
        chk("rmid_no_done_a", 32'(Done), 32'h0);
        step();
        chk("rmid_no_done_b", 32'(Done), 32'h0);
        chk("rmid_r1", 32'(bank[1]), 32'hFF34);
        Reset = 1'b1;

        // DEC after reset: pointer back at 0, requester 2 wins
        put(2, OP_DEC, 3'd3, 16'h0);
        step();
        chk("dec_gnt",  32'(Gnt),       32'h4);
        chk("dec_rege", 32'(RegE),      32'h8);
        chk("dec_fs",   32'(RegFunSel), 32'h0);
        Req = '0;
        step();
        chk("dec_done", 32'(Done), 32'h4);
        step();
        chk("dec_r3", 32'(bank[3]), 32'hA559);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
